// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flag, LSB-first data and FCS with zero insertion,
// closing flag, and abort sequence, one bit per enabled clock.
module hdlc_tx_framer #(
  parameter logic [7:0]  FLAG     = 8'h7E,
  parameter logic [7:0]  ABORT    = 8'hFE,
  parameter logic [15:0] CRC_POLY = 16'h8005,
  parameter logic [15:0] CRC_INIT = 16'h0000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       TxEN,
  input  logic       Tx_ValidFrame,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_AbortFrame,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLAG_OPEN,
    ST_DATA,
    ST_FCS,
    ST_FLAG_CLOSE,
    ST_ABORT
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_n;
  logic [4:0]  fcs_idx;
  logic [4:0]  fcs_n;
  logic [7:0]  shreg;
  logic [7:0]  sh_n;
  logic [15:0] crc;
  logic [15:0] crc_n;
  logic [2:0]  ones;
  logic [2:0]  ones_n;
  logic        tx_q;
  logic        tx_n;
  logic        done_q;
  logic        done_n;
  logic        abt_q;
  logic        abt_n;
  logic        pend;
  logic        pend_n;

  logic        abortable;
  logic        abort_req;
  logic        stuff;
  logic        fetch;
  logic        bit_d;
  logic        fb;

  assign abortable = (state == ST_FLAG_OPEN) ||
                     (state == ST_DATA) ||
                     (state == ST_FCS);

  assign abort_req = (Tx_AbortFrame | pend) & abortable;

  // five ones in a row force a zero before anything else advances
  assign stuff = ((state == ST_DATA) || (state == ST_FCS)) &&
                 (ones == 3'd5);

  assign fetch = Rst && TxEN && Tx_ValidFrame &&
                 (bit_idx == 3'd7) &&
                 ((state == ST_FLAG_OPEN) ||
                  ((state == ST_DATA) && !stuff));

  assign Tx_RdBuff       = fetch;
  assign Tx              = tx_q;
  assign Tx_Busy         = (state != ST_IDLE);
  assign Tx_Done         = done_q;
  assign Tx_AbortedTrans = abt_q;

  always_comb begin
    state_n = state;
    bit_n   = bit_idx;
    fcs_n   = fcs_idx;
    sh_n    = shreg;
    crc_n   = crc;
    ones_n  = ones;
    tx_n    = tx_q;
    done_n  = 1'b0;
    abt_n   = 1'b0;
    pend_n  = pend;
    bit_d   = 1'b1;
    fb      = 1'b0;

    if (!TxEN) begin
      if (Tx_AbortFrame && abortable) begin
        pend_n = 1'b1;
      end
    end else begin
      pend_n = 1'b0;
      unique case (state)
        ST_IDLE: begin
          tx_n = 1'b1;
          if (Tx_ValidFrame) begin
            state_n = ST_FLAG_OPEN;
            bit_n   = 3'd0;
            ones_n  = 3'd0;
            crc_n   = CRC_INIT;
          end
        end

        ST_FLAG_OPEN: begin
          tx_n  = FLAG[bit_idx];
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            if (Tx_ValidFrame) begin
              sh_n    = Tx_Data;
              state_n = ST_DATA;
            end else begin
              state_n = ST_FCS;
              fcs_n   = 5'd0;
            end
          end
        end

        ST_DATA: begin
          if (stuff) begin
            tx_n   = 1'b0;
            ones_n = 3'd0;
          end else begin
            bit_d  = shreg[bit_idx];
            tx_n   = bit_d;
            ones_n = bit_d ? ones + 3'd1 : 3'd0;
            fb     = bit_d ^ crc[15];
            crc_n  = {crc[14:0], 1'b0} ^
                     (fb ? CRC_POLY : 16'h0000);
            bit_n  = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (Tx_ValidFrame) begin
                sh_n = Tx_Data;
              end else begin
                state_n = ST_FCS;
                fcs_n   = 5'd0;
              end
            end
          end
        end

        ST_FCS: begin
          if (stuff) begin
            tx_n   = 1'b0;
            ones_n = 3'd0;
            // index 16 marks a trailing stuff owed after the last FCS bit
            if (fcs_idx == 5'd16) begin
              state_n = ST_FLAG_CLOSE;
              bit_n   = 3'd0;
            end
          end else begin
            bit_d  = crc[4'd15 - fcs_idx[3:0]];
            tx_n   = bit_d;
            ones_n = bit_d ? ones + 3'd1 : 3'd0;
            fcs_n  = fcs_idx + 5'd1;
            if ((fcs_idx == 5'd15) &&
                !(bit_d && (ones == 3'd4))) begin
              state_n = ST_FLAG_CLOSE;
              bit_n   = 3'd0;
              ones_n  = 3'd0;
            end
          end
        end

        ST_FLAG_CLOSE: begin
          tx_n  = FLAG[bit_idx];
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end

        ST_ABORT: begin
          tx_n  = ABORT[bit_idx];
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end

        default: begin
          state_n = ST_IDLE;
          tx_n    = 1'b1;
        end
      endcase

      if (abort_req) begin
        state_n = ST_ABORT;
        bit_n   = 3'd0;
        ones_n  = 3'd0;
        abt_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= ST_IDLE;
      bit_idx <= 3'd0;
      fcs_idx <= 5'd0;
      shreg   <= 8'h00;
      crc     <= CRC_INIT;
      ones    <= 3'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
      pend    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_idx <= bit_n;
      fcs_idx <= fcs_n;
      shreg   <= sh_n;
      crc     <= crc_n;
      ones    <= ones_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
      abt_q   <= abt_n;
      pend    <= pend_n;
    end
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Randomized bench for hdlc_tx_framer against a bit-level frame model
// and a flag-hunting, destuffing receive model.
module tb_hdlc_tx_framer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       TxEN = 1'b0;
  logic       Tx_ValidFrame = 1'b0;
  logic [7:0] Tx_Data = 8'h00;
  logic       Tx_AbortFrame = 1'b0;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_Busy;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;

  hdlc_tx_framer dut (
    .Clk(Clk),
    .Rst(Rst),
    .TxEN(TxEN),
    .Tx_ValidFrame(Tx_ValidFrame),
    .Tx_Data(Tx_Data),
    .Tx_AbortFrame(Tx_AbortFrame),
    .Tx_RdBuff(Tx_RdBuff),
    .Tx(Tx),
    .Tx_Busy(Tx_Busy),
    .Tx_Done(Tx_Done),
    .Tx_AbortedTrans(Tx_AbortedTrans)
  );

  always #5 Clk = ~Clk;

  localparam logic [7:0]  FLAG_B  = 8'h7E;
  localparam logic [7:0]  ABORT_B = 8'hFE;
  localparam logic [16:0] GEN     = 17'h18005;

  int n_chk = 0;
  int n_fail = 0;
  byte unsigned fifo[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // remainder of polynomial division by the generator, MSB-first bits
  function automatic logic [15:0] poly_rem(input bit b[$]);
    bit a[$];
    logic [16:0] g;
    logic [15:0] r;
    g = GEN;
    a = b;
    r = '0;
    for (int i = 0; i + 16 < a.size(); i++)
      if (a[i])
        for (int j = 0; j < 17; j++) a[i+j] ^= g[16-j];
    if (a.size() >= 16)
      for (int j = 0; j < 16; j++) r[15-j] = a[a.size()-16+j];
    return r;
  endfunction

  function automatic bit is_flag(input bit r[$], input int i);
    logic [7:0] f;
    f = FLAG_B;
    for (int k = 0; k < 8; k++)
      if (r[i+k] != f[k]) return 1'b0;
    return 1'b1;
  endfunction

  // expected Tx samples on enabled cycles: idle 1, flag, stuffed payload,
  // flag, four idle 1s; pos maps each payload bit to its stuffed index
  task automatic build(input byte unsigned d[$],
                       output bit ex[$], output int pos[$]);
    bit m[$];
    bit z[$];
    bit st[$];
    logic [15:0] f;
    logic [7:0] by;
    logic [7:0] fl;
    int ones;
    ex.delete();
    pos.delete();
    fl = FLAG_B;
    foreach (d[b]) begin
      by = d[b];
      for (int k = 0; k < 8; k++) m.push_back(by[k]);
    end
    z = m;
    for (int k = 0; k < 16; k++) z.push_back(1'b0);
    f = poly_rem(z);
    for (int k = 15; k >= 0; k--) m.push_back(f[k]);
    ones = 0;
    foreach (m[i]) begin
      pos.push_back(st.size());
      st.push_back(m[i]);
      ones = m[i] ? ones + 1 : 0;
      if (ones == 5) begin
        st.push_back(1'b0);
        ones = 0;
      end
    end
    ex.push_back(1'b1);
    for (int k = 0; k < 8; k++) ex.push_back(fl[k]);
    foreach (st[i]) ex.push_back(st[i]);
    for (int k = 0; k < 8; k++) ex.push_back(fl[k]);
    for (int k = 0; k < 4; k++) ex.push_back(1'b1);
  endtask

  task automatic cycle(input bit en, input bit ab,
                       output bit tx, output bit rd, output bit dn,
                       output bit abt, output bit busy);
    TxEN          = en;
    Tx_AbortFrame = ab;
    Tx_ValidFrame = (fifo.size() > 0);
    Tx_Data       = (fifo.size() > 0) ? fifo[0] : 8'h00;
    #1;
    rd = Tx_RdBuff;
    if (rd && fifo.size() > 0) void'(fifo.pop_front());
    @(posedge Clk);
    @(negedge Clk);
    tx   = Tx;
    dn   = Tx_Done;
    abt  = Tx_AbortedTrans;
    busy = Tx_Busy;
    if (abt) fifo.delete();
  endtask

  task automatic rx_check(input string nm, input bit r[$],
                          input byte unsigned d[$]);
    int i0;
    int j;
    int ones;
    bit fin;
    bit pl[$];
    logic [7:0] by;
    i0 = -1;
    fin = 1'b0;
    ones = 0;
    for (int i = 0; i + 8 <= r.size(); i++)
      if (is_flag(r, i)) begin
        i0 = i;
        break;
      end
    check({nm, "_rx_open"}, (i0 >= 0), 1);
    if (i0 < 0) return;
    j = i0 + 8;
    while (j + 8 <= r.size()) begin
      if (is_flag(r, j)) begin
        fin = 1'b1;
        break;
      end
      if (ones == 5) ones = 0;
      else begin
        pl.push_back(r[j]);
        ones = r[j] ? ones + 1 : 0;
      end
      j++;
    end
    check({nm, "_rx_close"}, fin, 1);
    check({nm, "_rx_len"}, pl.size(), 8 * d.size() + 16);
    if (pl.size() != 8 * d.size() + 16) return;
    foreach (d[b]) begin
      for (int k = 0; k < 8; k++) by[k] = pl[8*b+k];
      check($sformatf("%s_rx_byte%0d", nm, b), by, d[b]);
    end
    check({nm, "_rx_fcs_rem"}, poly_rem(pl), 0);
  endtask

  task automatic run_frame(input string nm, input byte unsigned d[$],
                           input bit tog, input int ab_bit,
                           input int rst_bit);
    bit ex[$];
    bit rec[$];
    int pos[$];
    int wp[$];
    int wp2[$];
    int gp[$];
    int k, idx, cyc, n_dn, dn_at, n_ab, ab_at, dn_idx;
    bit tx, rd, dn, abt, busy, prev, en, ab;
    logic [7:0] ap;
    ap = ABORT_B;
    build(d, ex, pos);
    foreach (d[b]) wp.push_back(b == 0 ? 8 : 9 + pos[8*b-1]);
    dn_idx = ex.size() - 5;
    k = -1;
    if (ab_bit >= 0) begin
      k = 9 + pos[ab_bit];
      ex = ex[0:k];
      for (int i = 0; i < 8; i++) ex.push_back(ap[i]);
      for (int i = 0; i < 4; i++) ex.push_back(1'b1);
      dn_idx = k + 8;
      foreach (wp[i]) if (wp[i] <= k) wp2.push_back(wp[i]);
      wp = wp2;
    end
    if (rst_bit >= 0) k = 9 + pos[rst_bit];
    fifo = d;
    idx = 0; cyc = 0; n_dn = 0; dn_at = -1; n_ab = 0; ab_at = -1;
    prev = 1'b1;
    while (idx < ex.size() && cyc < 4 * ex.size() + 20) begin
      en = !tog || (cyc % 2 == 0);
      if (rst_bit >= 0 && en && idx == k) begin
        Rst = 1'b0;
        cycle(1'b1, 1'b0, tx, rd, dn, abt, busy);
        Rst = 1'b1;
        check({nm, "_rst_tx"}, tx, 1);
        check({nm, "_rst_busy"}, busy, 0);
        check({nm, "_rst_done"}, dn, 0);
        cycle(1'b1, 1'b0, tx, rd, dn, abt, busy);
        check({nm, "_post_rst_done"}, dn, 0);
        check({nm, "_post_rst_busy"}, busy, 0);
        return;
      end
      ab = (ab_bit >= 0) && (tog ? (!en && idx == k) : (idx == k));
      cycle(en, ab, tx, rd, dn, abt, busy);
      if (rd) gp.push_back(en ? idx : -1);
      if (dn) begin n_dn++; dn_at = en ? idx : -1; end
      if (abt) begin n_ab++; ab_at = en ? idx : -1; end
      if (en) begin
        check($sformatf("%s_tx%0d", nm, idx), tx, ex[idx]);
        rec.push_back(tx);
        idx++;
      end else begin
        check($sformatf("%s_hold%0d", nm, cyc), tx, prev);
      end
      prev = tx;
      cyc++;
    end
    check({nm, "_cycles"}, idx, ex.size());
    check({nm, "_pops"}, gp.size(), wp.size());
    foreach (wp[i])
      if (i < gp.size())
        check($sformatf("%s_pop%0d", nm, i), gp[i], wp[i]);
    check({nm, "_done_cnt"}, n_dn, 1);
    check({nm, "_done_at"}, dn_at, dn_idx);
    check({nm, "_abt_cnt"}, n_ab, (ab_bit >= 0) ? 1 : 0);
    if (ab_bit >= 0) check({nm, "_abt_at"}, ab_at, k);
    check({nm, "_busy_end"}, busy, 0);
    if (ab_bit < 0) rx_check(nm, rec, d);
  endtask

  function automatic void rand_bytes(output byte unsigned d[$], input int n);
    d.delete();
    for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
  endfunction

  initial begin
    byte unsigned d[$];
    bit tx, rd, dn, abt, busy;

    Rst = 1'b0;
    cycle(1'b1, 1'b0, tx, rd, dn, abt, busy);
    cycle(1'b1, 1'b0, tx, rd, dn, abt, busy);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", dn, 0);
    check("reset_abt", abt, 0);
    check("reset_rd", rd, 0);
    Rst = 1'b1;
    cycle(1'b1, 1'b0, tx, rd, dn, abt, busy);

    d = '{8'h00};
    run_frame("b00", d, 1'b0, -1, -1);
    d = '{8'hFF};
    run_frame("bFF", d, 1'b0, -1, -1);
    d = '{8'h7E, 8'h3C, 8'hAA};
    run_frame("three", d, 1'b0, -1, -1);

    for (int t = 0; t < 4; t++) begin
      rand_bytes(d, $urandom_range(1, 5));
      run_frame($sformatf("rnd%0d", t), d, 1'($urandom_range(0, 1)),
                -1, -1);
    end

    rand_bytes(d, 4);
    run_frame("en_full", d, 1'b0, -1, -1);
    run_frame("en_tog", d, 1'b1, -1, -1);

    rand_bytes(d, 3);
    run_frame("abort", d, 1'b0, 8 + $urandom_range(0, 6), -1);
    rand_bytes(d, 3);
    run_frame("abort_tog", d, 1'b1, 8 + $urandom_range(0, 6), -1);

    rand_bytes(d, 2);
    run_frame("rst_fcs", d, 1'b0, -1, 16 + $urandom_range(0, 15));
    d = '{8'hFF, 8'h5A};
    run_frame("after_rst", d, 1'b0, -1, -1);

    cycle(1'b1, 1'b1, tx, rd, dn, abt, busy);
    check("idle_abort_abt", abt, 0);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_tx", tx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_framer.md
Name: hdlc_tx_framer

Overview:
HDLC transmit channel, the mirror of the existing Rx channel. It takes frame bytes from the Tx buffer through a first-word-fall-through pop handshake and emits a serial bitstream on Tx, one bit per enabled Clk:
- opening flag;
- data, LSB first, with zero insertion;
- 16-bit FCS, with zero insertion;
- closing flag.

It also generates the abort sequence. It sits between the Tx buffer/register interface and the Tx pin of Hdlc.

Parameters:
FLAG, 8'h7E, frame delimiter, sent LSB first, never stuffed.
ABORT, 8'hFE, abort pattern, sent LSB first (0 then seven 1s), never stuffed.
CRC_POLY, 16'h8005, FCS polynomial x^16+x^15+x^2+1.
CRC_INIT, 16'h0000, FCS register value at frame start.

Ports:
Clk  in  1  system clock, all logic on rising edge.
Rst  in  1  synchronous active-low reset.
TxEN  in  1  bit enable; 1 = advance one bit this cycle, 0 = freeze all state and hold Tx.
Tx_ValidFrame  in  1  buffer holds at least one unsent byte of the current frame.
Tx_Data  in  8  byte at the buffer head, valid whenever Tx_ValidFrame=1.
Tx_AbortFrame  in  1  one-cycle abort request.
Tx_RdBuff  out  1  one-cycle pop; Tx_Data is captured in the same cycle.
Tx  out  1  registered serial output, idle 1.
Tx_Busy  out  1  1 in any state except IDLE.
Tx_Done  out  1  one-cycle pulse after the last closing-flag or abort bit.
Tx_AbortedTrans  out  1  one-cycle pulse when the abort pattern starts.

Behaviour:
- Reset (Rst=0 at an edge, including mid-frame): state IDLE. Tx=1; Tx_RdBuff, Tx_Done, Tx_Busy, Tx_AbortedTrans=0. Stuff counter=0, CRC=CRC_INIT.
- All transitions and bit emissions happen only on cycles with TxEN=1. Exceptions: reset, and clearing of the single-cycle output pulses.
- Tx is registered: the bit chosen in a cycle appears on Tx after that edge.
- IDLE: Tx=1. On Tx_ValidFrame=1, go to FLAG_OPEN and load CRC_INIT.
- FLAG_OPEN: emit FLAG bits 0..7. On the bit-7 cycle:
  - if Tx_ValidFrame=1: pulse Tx_RdBuff, capture Tx_Data into the shift register, go to DATA;
  - else (empty frame): go to FCS.
- DATA: emit shift register bits 0..7.
  - Each emitted data bit d updates the CRC: fb=d^c[15]; c<={c[14:0],1'b0}^(fb?CRC_POLY:0).
  - On the bit-7 cycle: if Tx_ValidFrame=1, pulse Tx_RdBuff and capture the next byte; else go to FCS.
  - Back-to-back bytes leave no gap other than stuffed zeros.
- FCS: emit the frozen CRC c[15] first down to c[0]. These bits do not update the CRC.
- Zero insertion (DATA and FCS only):
  - A counter counts consecutive emitted 1s and clears on any emitted 0.
  - After five 1s, the next cycle emits a stuffed 0 instead of advancing. Bit index, CRC and byte fetch are held for that cycle; the counter clears.
  - A stuffed 0 after bit 7 of a byte is emitted before the byte-boundary action takes effect. The fetch and capture still happen on the bit-7 cycle.
  - A stuffed 0 after the last FCS bit is emitted before FLAG_CLOSE.
  - The counter clears on entry to FLAG_OPEN, FLAG_CLOSE and ABORT.
- FLAG_CLOSE: emit FLAG bits 0..7, then go to IDLE. Tx_Done pulses on the cycle after the last flag bit is registered. A new frame may start from IDLE on that same cycle.
- Abort:
  - Tx_AbortFrame=1 in FLAG_OPEN, DATA or FCS: the current bit completes, then go to ABORT. Tx_AbortedTrans pulses on entry.
  - ABORT: emit ABORT bits 0..7, then go to IDLE with a Tx_Done pulse.
  - No Tx_RdBuff pulses during ABORT. The upstream buffer is responsible for flushing the remainder.
  - Tx_AbortFrame in IDLE, FLAG_CLOSE or ABORT is ignored.
  - If abort coincides with a byte-boundary fetch, the fetch still occurs and the byte is discarded.
- Simultaneous TxEN=0 and Tx_AbortFrame: the request is latched and acted on at the next enabled cycle.
- Tx_RdBuff is never asserted when Tx_ValidFrame=0.

Test Plan:
- Reset then single byte 8'h00, TxEN=1 -> Tx: 1s, 0111 1110, eight 0s, sixteen 0s (FCS=16'h0000), 0111 1110, then 1s. Exactly one Tx_RdBuff pulse. Tx_Done 1 cycle after the last flag bit.
- Single byte 8'hFF -> data bits 1,1,1,1,1,0,1,1,1 (stuffed 0 after the 5th one). FCS matches a reference CRC model of 8'hFF, MSB first with stuffing. Zero runs of more than five 1s outside flags/abort.
- Three-byte frame 8'h7E,8'h3C,8'hAA with Tx_ValidFrame held -> three Tx_RdBuff pulses, each on a bit-7 cycle, no idle gaps. The bench Rx model recovers the identical bytes with zero FCS remainder.
- Tx_AbortFrame during the 2nd data byte -> current bit finishes. Tx_AbortedTrans pulses, Tx emits 0,1,1,1,1,1,1,1 then idle 1s. Tx_Done pulses, no further Tx_RdBuff.
- TxEN toggled 1/0 every cycle during a frame -> Tx bitstream identical to the TxEN=1 case when sampled on enabled cycles. Tx holds on disabled cycles.
- Rst=0 mid-FCS -> next edge Tx=1, Tx_Busy=0, no Tx_Done. A new frame afterwards starts with a clean flag and CRC_INIT.
